// File: rtl/mm_pd_voter.sv
// Sign-sign Mueller-Muller phase-vote generator. It forms a ternary early/late vote per sample,
// accumulates the votes over Ndec-vote windows, and hands each window result over valid/ready.
module mm_pd_voter #(
    parameter int Nadc = 8,
    parameter int Nacc = 6,
    parameter int Ndec = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic signed [Nadc-1:0] din,
    input  logic signed [Nadc-1:0] dlev,
    output logic                   pd_valid,
    input  logic                   pd_ready,
    output logic signed [Nacc-1:0] pd_sum,
    output logic signed [1:0]      pd_sign,
    output logic                   ovf
);

    localparam int CntW = $clog2(Ndec);
    localparam logic [CntW-1:0] CntLast = CntW'(Ndec - 1);
    localparam logic signed [Nacc:0] SatHi = (Nacc + 1)'(2 ** (Nacc - 1) - 1);
    localparam logic signed [Nacc:0] SatLo = -SatHi;

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t                 state, state_next;
    logic [CntW-1:0]        cnt, cnt_next;
    logic signed [Nacc-1:0] acc, acc_next;
    logic                   d_prev_neg, se_prev_neg;

    logic                   d_neg, se_neg, a_neg, b_neg;
    logic signed [Nadc:0]   din_x, dlev_x, err;
    logic signed [1:0]      vote;
    logic signed [Nacc:0]   acc_x, vote_x, sum_x;
    logic signed [Nacc-1:0] acc_sat;
    logic signed [1:0]      sat_sign;
    logic                   hist_load, res_valid, load, xfer;

    // Signs are carried as "is negative" bits; zero counts as +1.
    always_comb begin
        din_x  = {din[Nadc-1], din};
        dlev_x = {dlev[Nadc-1], dlev};
        d_neg  = din[Nadc-1];
        err    = d_neg ? (din_x + dlev_x) : (din_x - dlev_x);
        se_neg = err[Nadc];
        // (se*d_prev - se_prev*d)/2 is zero when both products agree, else the sign of se*d_prev.
        a_neg  = se_neg ^ d_prev_neg;
        b_neg  = se_prev_neg ^ d_neg;
        if (a_neg == b_neg) vote = 2'sd0;
        else if (a_neg)     vote = -2'sd1;
        else                vote = 2'sd1;

        acc_x  = {acc[Nacc-1], acc};
        vote_x = {{(Nacc - 1){vote[1]}}, vote};
        sum_x  = acc_x + vote_x;
        if (sum_x > SatHi)      acc_sat = SatHi[Nacc-1:0];
        else if (sum_x < SatLo) acc_sat = SatLo[Nacc-1:0];
        else                    acc_sat = sum_x[Nacc-1:0];

        if (acc_sat > 0)      sat_sign = 2'sd1;
        else if (acc_sat < 0) sat_sign = -2'sd1;
        else                  sat_sign = 2'sd0;
    end

    // NOTE: every signal is defaulted first so no path through the case leaves a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc;
        hist_load  = 1'b0;
        res_valid  = 1'b0;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
            acc_next   = '0;
        end else begin
            unique case (state)
                // An enabled cycle seen in IDLE is the PRIME sample: history only, no vote.
                IDLE: begin
                    hist_load  = 1'b1;
                    state_next = ACC;
                end
                ACC: begin
                    hist_load = 1'b1;
                    if (cnt == CntLast) begin
                        res_valid = 1'b1;
                        cnt_next  = '0;
                        acc_next  = '0;
                    end else begin
                        cnt_next  = cnt + 1'b1;
                        acc_next  = acc_sat;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign xfer = pd_valid && pd_ready;
    assign load = res_valid && (!pd_valid || pd_ready);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            d_prev_neg  <= 1'b0;
            se_prev_neg <= 1'b0;
            pd_valid    <= 1'b0;
            pd_sum      <= '0;
            pd_sign     <= '0;
            ovf         <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            acc   <= acc_next;
            if (hist_load) begin
                d_prev_neg  <= d_neg;
                se_prev_neg <= se_neg;
            end else if (!en) begin
                d_prev_neg  <= 1'b0;
                se_prev_neg <= 1'b0;
            end

            // A result arriving against a stalled consumer is dropped and flagged.
            if (load) begin
                pd_valid <= 1'b1;
                pd_sum   <= acc_sat;
                pd_sign  <= sat_sign;
            end else if (xfer) begin
                pd_valid <= 1'b0;
            end
            if (res_valid && pd_valid && !pd_ready) ovf <= 1'b1;
        end
    end

endmodule
